// File: rtl/mac_pkg.sv
// mac_pkg: shared types and width helpers
// for the rgals MAC datapath.
package mac_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } mac_state_e;

  function automatic int acc_w(
    input int w,
    input int n
  );
    return 2*w + $clog2(n);
  endfunction

endpackage

// File: rtl/mac_accum_ctrl.sv
// mac_accum_ctrl: group FSM and term counter
// steering the accumulator register.
module mac_accum_ctrl
  import mac_pkg::*;
#(
  parameter int p_nterms = 4,
  parameter int CW = $clog2(p_nterms) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_val,
  input  logic          resp_rdy,
  output logic          req_rdy,
  output logic          resp_val,
  output logic          acc_clear,
  output logic          acc_load,
  output logic          acc_en,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] LAST = CW'(p_nterms - 1);
  localparam logic [CW-1:0] FULL = CW'(p_nterms);

  mac_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and counter registers, sync active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ACC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, handshakes and accumulator steering
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_rdy   = 1'b0;
    resp_val  = 1'b0;
    acc_clear = 1'b0;
    acc_load  = 1'b0;
    acc_en    = 1'b0;
    unique case (state_q)
      ACC: begin
        req_rdy = 1'b1;
        if (req_val) begin
          acc_en = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        resp_val = 1'b1;
        req_rdy  = resp_rdy;
        if (resp_rdy) begin
          if (req_val) begin
            acc_load = 1'b1;
            if (p_nterms == 1) begin
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              cnt_d   = CW'(1);
              state_d = ACC;
            end
          end else begin
            acc_clear = 1'b1;
            cnt_d     = '0;
            state_d   = ACC;
          end
        end
      end
      default: begin
        state_d = ACC;
        cnt_d   = '0;
      end
    endcase
  end

  assign count = (state_q == DONE) ? FULL : cnt_q;

endmodule

// File: rtl/mac_accum.sv
// mac_accum: sums p_nterms unsigned products
// per group and emits the sum on val/rdy.
module mac_accum
  import mac_pkg::*;
#(
  parameter int p_width     = 4,
  parameter int p_nterms    = 4,
  parameter int p_acc_width = acc_w(p_width, p_nterms)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic [2*p_width-1:0]     req_msg,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic [p_acc_width-1:0]   resp_msg,
  output logic [$clog2(p_nterms):0] count
);

  localparam int CW = $clog2(p_nterms) + 1;
  localparam int AW = p_acc_width;

  logic          acc_clear;
  logic          acc_load;
  logic          acc_en;
  logic [AW-1:0] prod;
  logic [AW-1:0] acc_q, acc_d;

  mac_accum_ctrl #(
    .p_nterms (p_nterms),
    .CW       (CW)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .resp_rdy  (resp_rdy),
    .req_rdy   (req_rdy),
    .resp_val  (resp_val),
    .acc_clear (acc_clear),
    .acc_load  (acc_load),
    .acc_en    (acc_en),
    .count     (count)
  );

  assign prod = AW'(req_msg);

  // Accumulator next value: clear, bypass load or add
  always_comb begin
    acc_d = acc_q;
    unique case (1'b1)
      acc_clear: acc_d = '0;
      acc_load:  acc_d = prod;
      acc_en:    acc_d = acc_q + prod;
      default:   acc_d = acc_q;
    endcase
  end

  // Accumulator register, sync active-low reset
  always_ff @(posedge clk) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign resp_msg = acc_q;

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: directed checks of mac_accum
// for p_nterms=4 and p_nterms=1 builds.
module tb_mac_accum;

  localparam int W   = 4;
  localparam int N   = 4;
  localparam int AW  = 10;
  localparam int CW  = 3;
  localparam int AW1 = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_val;
  logic          req_rdy;
  logic [7:0]    req_msg;
  logic          resp_val;
  logic          resp_rdy;
  logic [AW-1:0] resp_msg;
  logic [CW-1:0] count;

  logic           req_val1;
  logic           req_rdy1;
  logic [7:0]     req_msg1;
  logic           resp_val1;
  logic           resp_rdy1;
  logic [AW1-1:0] resp_msg1;
  logic [0:0]     count1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mac_accum #(.p_width(W), .p_nterms(N)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg),
    .count    (count)
  );

  mac_accum #(.p_width(W), .p_nterms(1)) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val1),
    .req_rdy  (req_rdy1),
    .req_msg  (req_msg1),
    .resp_val (resp_val1),
    .resp_rdy (resp_rdy1),
    .resp_msg (resp_msg1),
    .count    (count1)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    req_val = 1'b1;
    req_msg = 8'd99;
    resp_rdy = 1'b1;
    req_val1 = 1'b0;
    req_msg1 = 8'd0;
    resp_rdy1 = 1'b1;
    repeat (2) cyc();
    reset   = 1'b1;
    req_val = 1'b0;
    #1;
    n_chk++;
    if (resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_resp_val got %0b want 0", resp_val);
    end
    n_chk++;
    if (req_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_req_rdy got %0b want 1", req_rdy);
    end
    n_chk++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_count got %0d want 0", count);
    end
    n_chk++;
    if (resp_msg !== 10'd0) begin
      n_fail++;
      $display("FAIL rst_resp_msg got %0d want 0", resp_msg);
    end
    n_chk++;
    if (resp_val1 !== 1'b0 || count1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_n1 got val=%0b cnt=%0d want 0/0",
               resp_val1, count1);
    end
    cyc();
    n_chk++;
    if (count !== 3'd0 || resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_rst got cnt=%0d val=%0b want 0/0",
               count, resp_val);
    end
  endtask

  task automatic test_basic();
    logic [7:0] v [4];
    v = '{8'd3, 8'd5, 8'd7, 8'd9};
    resp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_val = 1'b1;
      req_msg = v[i];
      cyc();
      if (i == 1) begin
        n_chk++;
        if (count !== 3'd2) begin
          n_fail++;
          $display("FAIL basic_mid_count got %0d want 2", count);
        end
      end
    end
    req_val = 1'b0;
    req_msg = 8'hxx;
    #1;
    n_chk++;
    if (resp_val !== 1'b1 || resp_msg !== 10'd24 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL basic_sum got val=%0b msg=%0d cnt=%0d want 1/24/4",
               resp_val, resp_msg, count);
    end
    cyc();
    n_chk++;
    if (resp_val !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_drain got val=%0b cnt=%0d want 0/0",
               resp_val, count);
    end
  endtask

  task automatic test_max_backpressure();
    resp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_val = 1'b1;
      req_msg = 8'd225;
      cyc();
    end
    req_val = 1'b1;
    req_msg = 8'd77;
    #1;
    n_chk++;
    if (resp_val !== 1'b1 || resp_msg !== 10'd900) begin
      n_fail++;
      $display("FAIL max_sum got val=%0b msg=%0d want 1/900",
               resp_val, resp_msg);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      n_chk++;
      if (resp_msg !== 10'd900 || req_rdy !== 1'b0 ||
          resp_val !== 1'b1 || count !== 3'd4) begin
        n_fail++;
        $display("FAIL stall_%0d got msg=%0d rdy=%0b val=%0b cnt=%0d want 900/0/1/4",
                 i, resp_msg, req_rdy, resp_val, count);
      end
    end
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    #1;
    n_chk++;
    if (req_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rdy_passthru got %0b want 1", req_rdy);
    end
    cyc();
    n_chk++;
    if (resp_val !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL stall_release got val=%0b cnt=%0d want 0/0",
               resp_val, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [4];
    v = '{8'd3, 8'd5, 8'd7, 8'd9};
    resp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_val = 1'b1;
      req_msg = v[i];
      cyc();
    end
    req_val = 1'b1;
    req_msg = 8'd10;
    #1;
    n_chk++;
    if (resp_msg !== 10'd24 || resp_val !== 1'b1 || req_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_pend got msg=%0d val=%0b rdy=%0b want 24/1/1",
               resp_msg, resp_val, req_rdy);
    end
    cyc();
    n_chk++;
    if (resp_val !== 1'b0 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL bypass_load got val=%0b cnt=%0d want 0/1",
               resp_val, count);
    end
    for (int i = 0; i < 3; i++) begin
      req_val = 1'b1;
      req_msg = 8'd1;
      cyc();
    end
    req_val = 1'b0;
    #1;
    n_chk++;
    if (resp_val !== 1'b1 || resp_msg !== 10'd13 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL bypass_sum got val=%0b msg=%0d cnt=%0d want 1/13/4",
               resp_val, resp_msg, count);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    resp_rdy = 1'b1;
    req_val = 1'b1;
    req_msg = 8'd50;
    cyc();
    req_msg = 8'd60;
    cyc();
    req_val = 1'b0;
    reset   = 1'b0;
    cyc();
    reset = 1'b1;
    n_chk++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_count got %0d want 0", count);
    end
    for (int i = 1; i <= 4; i++) begin
      req_val = 1'b1;
      req_msg = 8'(i);
      cyc();
    end
    req_val = 1'b0;
    #1;
    n_chk++;
    if (resp_val !== 1'b1 || resp_msg !== 10'd10) begin
      n_fail++;
      $display("FAIL midrst_sum got val=%0b msg=%0d want 1/10",
               resp_val, resp_msg);
    end
    cyc();
  endtask

  task automatic test_nterms1();
    logic [7:0] v [3];
    v = '{8'd7, 8'd8, 8'd9};
    resp_rdy1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_val1 = 1'b1;
      req_msg1 = v[i];
      cyc();
      if (i == 2) req_val1 = 1'b0;
      #1;
      n_chk++;
      if (resp_val1 !== 1'b1 || resp_msg1 !== AW1'(v[i]) ||
          count1 !== 1'b1) begin
        n_fail++;
        $display("FAIL n1_sum_%0d got val=%0b msg=%0d cnt=%0d want 1/%0d/1",
                 i, resp_val1, resp_msg1, count1, v[i]);
      end
    end
    cyc();
    n_chk++;
    if (resp_val1 !== 1'b0) begin
      n_fail++;
      $display("FAIL n1_drain got val=%0b want 0", resp_val1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_nterms1();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
